instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage directly upstream of the control unit and datapath.
//  - Holds the PC and fetches one instruction per request from instruction memory (variable latency, req/ack).
//  - Presents op/func3/func7 to the control unit and the full instruction word to the datapath.
//  - Applies the next-PC choice (pcSrc/pcTarget) when the instruction is consumed.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset (must be 4-byte aligned)
//  NOP_WORD  32'h0000_0013  word driven on instr while instrValid=0 (addi x0,x0,0)
// PORTS
//  clk         in   1   single clock; all state updates on rising edge
//  reset       in   1   synchronous, active-high
//  imemReq     out  1   fetch request to instruction memory
//  imemAddr    out  32  fetch address; stable while imemReq=1
//  imemAck     in   1   imemData valid this cycle
//  imemData    in   32  fetched instruction word
//  stall       in   1   downstream cannot consume the held instruction this cycle
//  pcSrc       in   1   from control unit: take pcTarget instead of pc+4
//  pcTarget    in   32  branch/jump target from datapath
//  instrValid  out  1   instr/pc/fields hold a valid instruction
//  instr       out  32  instruction word (NOP_WORD when instrValid=0)
//  op          out  7   instr[6:0]
//  func3       out  3   instr[14:12]
//  func7       out  1   instr[30]
//  pc          out  32  address of the held instruction
//  pcPlus4     out  32  pc+4, mod 2^32
//  misalign    out  1   1-cycle pulse: pcTarget[1:0]!=0 was taken
//  retired     out  32  count of consumed instructions, wraps mod 2^32
// BEHAVIOUR
//  Reset (sync, active-high), values in cycle after the reset edge:
//  - state=IDLE, fetchPc=RESET_PC, pc=RESET_PC, imemReq=0, instrValid=0.
//  - instr=NOP_WORD, misalign=0, retired=0.
//  - Reset wins over every other input in the same cycle.
//  FSM IDLE -> FETCH -> HOLD -> FETCH ...
//  - IDLE: exactly one cycle after reset; imemReq=0; imemAck ignored; -> FETCH.
//  - FETCH: imemReq=1, imemAddr=fetchPc (constant until ack).
//    - On imemAck: IR<=imemData, pc<=fetchPc, instrValid<=1; -> HOLD.
//    - No ack: stay in FETCH, no timeout.
//  - HOLD: imemReq=0; imemAck ignored; outputs stable.
//    - Consume = instrValid & !stall, sampled at the clock edge. On consume:
//      - fetchPc <= pcSrc ? {pcTarget[31:2],2'b00} : pc+4
//      - instrValid<=0, retired<=retired+1; -> FETCH.
//    - stall=1: hold indefinitely, no request issued.
//  Timing:
//  - Latency: ack in the first FETCH cycle -> instrValid in the next cycle.
//  - Best throughput is 1 instruction per 2 cycles.
//  - pcSrc/pcTarget are sampled only at the consume edge; ignored otherwise.
//  Field decode:
//  - instr/op/func3/func7 are combinational from (instrValid ? IR : NOP_WORD).
//  - The control unit therefore sees a write-free NOP whenever the stage is empty.
//  Wrap and alignment:
//  - pc+4 at 32'hFFFF_FFFC wraps to 0; no flag.
//  - Misaligned target: low 2 bits forced to 0; misalign=1 for the cycle after consume.
//  Reset mid-fetch: the outstanding request is abandoned; an ack arriving during IDLE is dropped.
// TESTING
//  1 RESET_PC=0x100, release reset -> IDLE cycle req=0; next cycle req=1 addr=0x100; instrValid=0, instr=0x13.
//  2 Zero-wait ack, stall=0, pcSrc=0 -> addrs 0x100,0x104,0x108 every 2 cycles; retired 1,2,3; op matches imemData[6:0].
//  3 stall=1 for 3 cycles in HOLD -> instr/pc/retired stable, imemReq=0; stall=0 -> next addr pc+4.
//  4 pcSrc=1 pcTarget=0x200 at consume -> next addr 0x200, misalign=0; pcTarget=0x202 -> addr 0x200, misalign pulse of 1 cycle.
//  5 pc=0xFFFF_FFFC consumed with pcSrc=0 -> pcPlus4=0, next imemAddr=0.
//  6 reset during FETCH (ack delayed 3 cycles) -> req=0 next cycle; late ack in IDLE ignored, instrValid stays 0, refetch at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, fetches one word per request over a
// variable-latency req/ack port, and presents the held instruction (or a NOP
// when empty) to the control unit and datapath.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  input  logic        stall,
  input  logic        pcSrc,
  input  logic [31:0] pcTarget,
  output logic        instrValid,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [2:0]  func3,
  output logic        func7,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic        misalign,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        instr_valid_q, instr_valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] retired_q, retired_d;
  logic [31:0] pc_plus4;
  logic [31:0] instr_word;

  assign pc_plus4 = pc_q + 32'd4;

  // Next-state logic: sequence IDLE -> FETCH -> HOLD -> FETCH and pick next PC on consume.
  always_comb begin
    state_d       = state_q;
    imem_req_d    = imem_req_q;
    fetch_pc_d    = fetch_pc_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    instr_valid_d = instr_valid_q;
    misalign_d    = 1'b0;
    retired_d     = retired_q;
    unique case (state_q)
      IDLE: begin
        // Any ack here belongs to a request abandoned by reset and is dropped.
        state_d    = FETCH;
        imem_req_d = 1'b1;
      end
      FETCH: begin
        if (imemAck) begin
          ir_d          = imemData;
          pc_d          = fetch_pc_q;
          instr_valid_d = 1'b1;
          imem_req_d    = 1'b0;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (instr_valid_q && !stall) begin
          // Targets are word-aligned by dropping the low bits; flag that it happened.
          fetch_pc_d    = pcSrc ? {pcTarget[31:2], 2'b00} : pc_plus4;
          misalign_d    = pcSrc && (pcTarget[1:0] != 2'b00);
          instr_valid_d = 1'b0;
          retired_d     = retired_q + 32'd1;
          imem_req_d    = 1'b1;
          state_d       = FETCH;
        end
      end
      default: begin
        state_d    = IDLE;
        imem_req_d = 1'b0;
      end
    endcase
  end

  // Control state registers with synchronous reset; reset overrides all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      imem_req_q    <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      pc_q          <= RESET_PC;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      retired_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      imem_req_q    <= imem_req_d;
      fetch_pc_q    <= fetch_pc_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
      retired_q     <= retired_d;
    end
  end

  // Instruction register: data only, masked by instrValid so it needs no reset.
  always_ff @(posedge clk) begin
    ir_q <= ir_d;
  end

  assign instr_word = instr_valid_q ? ir_q : NOP_WORD;

  assign imemReq    = imem_req_q;
  assign imemAddr   = fetch_pc_q;
  assign instrValid = instr_valid_q;
  assign instr      = instr_word;
  assign op         = instr_word[6:0];
  assign func3      = instr_word[14:12];
  assign func7      = instr_word[30];
  assign pc         = pc_q;
  assign pcPlus4    = pc_plus4;
  assign misalign   = misalign_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// run, checked against a transaction-level model of the fetch/consume rules.
module tb_instr_fetch;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic        stall;
  logic        pcSrc;
  logic [31:0] pcTarget;
  logic        instrValid;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  func3;
  logic        func7;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        misalign;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;

  // Reference model: address the next fetch must use, and instructions consumed.
  logic [31:0] exp_addr;
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  logic [31:0] exp_retired;

  instr_fetch #(.RESET_PC(RPC), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .stall(stall), .pcSrc(pcSrc), .pcTarget(pcTarget),
    .instrValid(instrValid), .instr(instr), .op(op), .func3(func3), .func7(func7),
    .pc(pc), .pcPlus4(pcPlus4), .misalign(misalign), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Empty stage: NOP presented, nothing retired beyond model count.
  task automatic check_empty(input string tag);
    check({tag, ".valid"}, {31'd0, instrValid}, 32'd0);
    check({tag, ".instr"}, instr, NOP);
    check({tag, ".op"}, {25'd0, op}, 32'h13);
    check({tag, ".retired"}, retired, exp_retired);
  endtask

  // Serve one fetch after 'delay' wait cycles; the model says which address is due.
  task automatic fetch(input logic [31:0] data, input int delay);
    check("fetch.req", {31'd0, imemReq}, 32'd1);
    check("fetch.addr", imemAddr, exp_addr);
    for (int i = 0; i < delay; i++) begin
      imemAck = 1'b0;
      pcSrc = 1'($urandom);
      pcTarget = $urandom;
      tick();
      check("wait.req", {31'd0, imemReq}, 32'd1);
      check("wait.addr", imemAddr, exp_addr);
      check("wait.valid", {31'd0, instrValid}, 32'd0);
      check("wait.misalign", {31'd0, misalign}, 32'd0);
    end
    imemAck = 1'b1;
    imemData = data;
    tick();
    imemAck = 1'b0;
    imemData = $urandom;
    exp_pc = exp_addr;
    exp_instr = data;
    check("ack.valid", {31'd0, instrValid}, 32'd1);
    check("ack.instr", instr, data);
    check("ack.op", {25'd0, op}, {25'd0, data[6:0]});
    check("ack.func3", {29'd0, func3}, {29'd0, data[14:12]});
    check("ack.func7", {31'd0, func7}, {31'd0, data[30]});
    check("ack.pc", pc, exp_pc);
    check("ack.pcPlus4", pcPlus4, exp_pc + 32'd4);
    check("ack.req", {31'd0, imemReq}, 32'd0);
    check("ack.misalign", {31'd0, misalign}, 32'd0);
  endtask

  // Hold for 'stalls' cycles (with noise on ignored inputs), then consume.
  task automatic consume(input int stalls, input logic src, input logic [31:0] tgt);
    for (int i = 0; i < stalls; i++) begin
      stall = 1'b1;
      pcSrc = 1'($urandom);
      pcTarget = $urandom;
      imemAck = 1'($urandom);
      tick();
      imemAck = 1'b0;
      check("hold.valid", {31'd0, instrValid}, 32'd1);
      check("hold.instr", instr, exp_instr);
      check("hold.pc", pc, exp_pc);
      check("hold.retired", retired, exp_retired);
      check("hold.req", {31'd0, imemReq}, 32'd0);
    end
    stall = 1'b0;
    pcSrc = src;
    pcTarget = tgt;
    tick();
    pcSrc = 1'($urandom);
    pcTarget = $urandom;
    exp_retired = exp_retired + 32'd1;
    exp_addr = src ? (tgt & 32'hFFFF_FFFC) : (exp_pc + 32'd4);
    check_empty("consume");
    check("consume.misalign", {31'd0, misalign}, {31'd0, (src && tgt[1:0] != 2'b00)});
    check("consume.req", {31'd0, imemReq}, 32'd1);
    check("consume.addr", imemAddr, exp_addr);
  endtask

  initial begin
    logic [31:0] t;
    reset = 1'b1;
    imemAck = 1'b0;
    imemData = 32'd0;
    stall = 1'b0;
    pcSrc = 1'b0;
    pcTarget = 32'd0;
    exp_addr = RPC;
    exp_pc = RPC;
    exp_instr = NOP;
    exp_retired = 32'd0;

    // Reset state and the single IDLE cycle.
    tick();
    tick();
    reset = 1'b0;
    check_empty("reset");
    check("reset.req", {31'd0, imemReq}, 32'd0);
    check("reset.pc", pc, RPC);
    check("reset.misalign", {31'd0, misalign}, 32'd0);
    imemAck = 1'b1;
    tick();
    imemAck = 1'b0;
    check_empty("first");
    check("first.req", {31'd0, imemReq}, 32'd1);
    check("first.addr", imemAddr, RPC);

    // Zero-wait sequential fetches.
    fetch(32'h0051_0093, 0);
    consume(0, 1'b0, 32'd0);
    fetch(32'h4020_81B3, 0);
    consume(0, 1'b0, 32'd0);
    fetch(32'h0000_6F13, 0);
    consume(3, 1'b0, 32'd0);

    // Taken targets, aligned then misaligned (pulse lasts one cycle).
    fetch(32'h0080_006F, 1);
    consume(0, 1'b1, 32'h0000_0200);
    fetch(32'h00C0_0067, 0);
    consume(1, 1'b1, 32'h0000_0202);
    fetch(32'hFE00_0EE3, 0);

    // PC wrap at the top of the address space.
    consume(0, 1'b1, 32'hFFFF_FFFC);
    fetch(32'h0000_0013, 2);
    check("wrap.pcPlus4", pcPlus4, 32'd0);
    consume(0, 1'b0, 32'd0);
    check("wrap.addr", imemAddr, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      fetch($urandom, $urandom_range(0, 3));
      t = $urandom;
      if ($urandom_range(0, 3) == 0) t[1:0] = 2'b01;
      consume($urandom_range(0, 3), 1'($urandom), t);
    end

    // Reset while a request is outstanding; late ack during IDLE is dropped.
    tick();
    tick();
    check("midfetch.req", {31'd0, imemReq}, 32'd1);
    reset = 1'b1;
    imemAck = 1'b1;
    imemData = 32'hDEAD_BEEF;
    tick();
    reset = 1'b0;
    exp_retired = 32'd0;
    exp_addr = RPC;
    check("rst.req", {31'd0, imemReq}, 32'd0);
    check_empty("rst");
    tick();
    imemAck = 1'b0;
    check_empty("lateack");
    check("lateack.req", {31'd0, imemReq}, 32'd1);
    check("lateack.addr", imemAddr, RPC);
    fetch(32'h0010_0093, 0);
    consume(0, 1'b0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
